// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch stage. Owns the PC, fetches one word per
//                step over a req/ack handshake and presents it to the decoder
//                for exactly one execute cycle. Halts when the decoder drops
//                load and waits for resume.
//                Optional feature macro: FETCH_RETIRE_CNT_EN (enables the
//                retired-instruction counter; otherwise retired_cnt is 0).
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        load,
  input  logic        pc_src,
  input  logic [31:0] pc_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        resume,
  output logic        halted,
  output logic [31:0] retired_cnt
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_EXEC   = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_pc_next;
  logic        w_pc_load;
  logic        w_instr_load;
  logic        w_retire;
  logic        w_imem_req;
  logic        w_instr_valid;
  logic        w_halted;

  // Sequential increment wraps naturally at 2^32.
  assign w_pc_plus4 = r_pc + 32'd4;

  // Next-state, PC/instruction update enables and state-decoded outputs.
  always_comb begin
    w_state_next  = r_state;
    w_pc_next     = w_pc_plus4;
    w_pc_load     = 1'b0;
    w_instr_load  = 1'b0;
    w_retire      = 1'b0;
    w_imem_req    = 1'b0;
    w_instr_valid = 1'b0;
    w_halted      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_state_next = S_REQ;
      end
      S_REQ: begin
        w_imem_req = 1'b1;
        if (imem_ack) begin
          w_instr_load = 1'b1;
          w_state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        w_instr_valid = 1'b1;
        if (load) begin
          // Branch targets are forced word-aligned.
          w_pc_next    = pc_src ? (pc_target & 32'hFFFF_FFFC) : w_pc_plus4;
          w_pc_load    = 1'b1;
          w_retire     = 1'b1;
          w_state_next = S_REQ;
        end else begin
          // PC stays on the halt word so software can inspect it.
          w_state_next = S_HALTED;
        end
      end
      S_HALTED: begin
        w_halted = 1'b1;
        if (resume) begin
          w_pc_next    = w_pc_plus4;
          w_pc_load    = 1'b1;
          w_state_next = S_REQ;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State register; reset abandons any outstanding fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Program counter and fetched instruction registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc    <= RESET_PC;
      r_instr <= NOP_INSTR;
    end else begin
      if (w_pc_load) begin
        r_pc <= w_pc_next;
      end
      if (w_instr_load) begin
        r_instr <= imem_rdata;
      end
    end
  end

`ifdef FETCH_RETIRE_CNT_EN
  logic [31:0] r_retired_cnt;

  // Count instructions that completed EXEC with load=1; halts are not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_retired_cnt <= 32'h0;
    end else if (w_retire) begin
      r_retired_cnt <= r_retired_cnt + 32'd1;
    end
  end

  assign retired_cnt = r_retired_cnt;
`else
  assign retired_cnt = 32'h0;
`endif

  assign imem_req    = w_imem_req;
  assign imem_addr   = r_pc;
  assign instr       = r_instr;
  assign instr_valid = w_instr_valid;
  assign pc          = r_pc;
  assign pc_plus4    = w_pc_plus4;
  assign halted      = w_halted;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit: a cycle-by-cycle vector
//                table followed by hand-written halt/resume, counter and PC
//                wrap-around sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

`ifdef FETCH_RETIRE_CNT_EN
  localparam bit c_CNT_EN = 1'b1;
`else
  localparam bit c_CNT_EN = 1'b0;
`endif
  localparam logic [31:0] c_NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        load;
  logic        pc_src;
  logic [31:0] pc_target;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        resume;
  logic        halted;
  logic [31:0] retired_cnt;

  int n_pass  = 0;
  int n_total = 0;

  fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (c_NOP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .load        (load),
    .pc_src      (pc_src),
    .pc_target   (pc_target),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .resume      (resume),
    .halted      (halted),
    .retired_cnt (retired_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        rst;
    logic        ack;
    logic [31:0] rdata;
    logic        load;
    logic        src;
    logic [31:0] tgt;
    logic        res;
    bit          chk;
    logic        e_req;
    logic        e_valid;
    logic        e_halted;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic a, input logic [31:0] rd,
                     input logic ld, input logic s, input logic [31:0] t,
                     input logic rs, input bit c, input logic er,
                     input logic ev, input logic eh, input logic [31:0] ep,
                     input logic [31:0] ei, input logic [31:0] ec);
    vec_t v;
    v.rst = r; v.ack = a; v.rdata = rd; v.load = ld; v.src = s; v.tgt = t;
    v.res = rs; v.chk = c; v.e_req = er; v.e_valid = ev; v.e_halted = eh;
    v.e_pc = ep; v.e_instr = ei; v.e_cnt = ec;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  // Advance one clock; inputs are changed and outputs sampled at negedge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rst = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0; load = 1'b0;
    pc_src = 1'b0; pc_target = 32'h0; resume = 1'b0;
  endtask

  // Complete one fetch: wait (bounded) for REQ, ack with data, then answer
  // the EXEC cycle with the given decoder/branch values.
  task automatic do_fetch(input string tag, input logic [31:0] e_addr,
                          input logic [31:0] rd, input logic ld,
                          input logic s, input logic [31:0] t);
    int n;
    n = 0;
    while (imem_req !== 1'b1 && n < 10) begin
      cyc();
      n++;
    end
    chk({tag, "_req"}, {31'h0, imem_req}, 32'h1);
    chk({tag, "_addr"}, imem_addr, e_addr);
    imem_ack = 1'b1; imem_rdata = rd;
    cyc();
    imem_ack = 1'b0; imem_rdata = 32'h0;
    chk({tag, "_valid"}, {31'h0, instr_valid}, 32'h1);
    chk({tag, "_instr"}, instr, rd);
    load = ld; pc_src = s; pc_target = t;
    cyc();
    load = 1'b0; pc_src = 1'b0; pc_target = 32'h0;
  endtask

  initial begin
    idle_inputs();
    //  rst ack rdata          ld src tgt            res chk req val hlt pc            instr          cnt
    add(1, 0, 32'h0,          0, 0, 32'h0,          0,  0,  0,  0,  0, 32'h0,         32'h0,         0); // 0
    add(0, 0, 32'h0,          0, 0, 32'h0,          0,  1,  0,  0,  0, 32'h0,         c_NOP,         0); // 1 IDLE
    add(0, 1, 32'h33,         0, 0, 32'h0,          0,  1,  1,  0,  0, 32'h0,         c_NOP,         0); // 2 REQ 0
    add(0, 0, 32'h0,          1, 0, 32'h0,          0,  1,  0,  1,  0, 32'h0,         32'h33,        0); // 3 EXEC
    add(0, 1, 32'h33,         0, 0, 32'h0,          0,  1,  1,  0,  0, 32'h4,         32'h33,        1); // 4 REQ 4
    add(0, 0, 32'h0,          1, 0, 32'h0,          0,  1,  0,  1,  0, 32'h4,         32'h33,        1); // 5
    add(0, 1, 32'h33,         0, 0, 32'h0,          0,  1,  1,  0,  0, 32'h8,         32'h33,        2); // 6 REQ 8
    add(0, 0, 32'h0,          1, 0, 32'h0,          0,  1,  0,  1,  0, 32'h8,         32'h33,        2); // 7
    add(0, 0, 32'h0,          0, 0, 32'h0,          0,  1,  1,  0,  0, 32'hC,         32'h33,        3); // 8 wait 1
    add(0, 0, 32'h0,          0, 0, 32'h0,          1,  1,  1,  0,  0, 32'hC,         32'h33,        3); // 9 wait 2, resume ignored
    add(0, 0, 32'h0,          0, 0, 32'h0,          0,  1,  1,  0,  0, 32'hC,         32'h33,        3); // 10 wait 3
    add(0, 1, 32'h0010_0093,  0, 0, 32'h0,          0,  1,  1,  0,  0, 32'hC,         32'h33,        3); // 11 ack
    add(0, 0, 32'h0,          1, 0, 32'h0,          0,  1,  0,  1,  0, 32'hC,         32'h0010_0093, 3); // 12 EXEC
    add(0, 1, 32'h33,         0, 0, 32'h0,          0,  1,  1,  0,  0, 32'h10,        32'h0010_0093, 4); // 13 REQ 10
    add(0, 0, 32'h0,          1, 1, 32'h43,         0,  1,  0,  1,  0, 32'h10,        32'h33,        4); // 14 branch 43
    add(0, 1, 32'h33,         0, 0, 32'h0,          0,  1,  1,  0,  0, 32'h40,        32'h33,        5); // 15 REQ 40
    add(0, 0, 32'h0,          1, 1, 32'h12,         0,  1,  0,  1,  0, 32'h40,        32'h33,        5); // 16 branch 12
    add(0, 1, 32'h33,         0, 0, 32'h0,          0,  1,  1,  0,  0, 32'h10,        32'h33,        6); // 17 REQ 10
    add(0, 0, 32'h0,          1, 0, 32'h43,         0,  1,  0,  1,  0, 32'h10,        32'h33,        6); // 18 not taken
    add(0, 1, 32'h0,          0, 0, 32'h0,          0,  1,  1,  0,  0, 32'h14,        32'h33,        7); // 19 REQ 14
    add(0, 0, 32'h0,          0, 0, 32'h0,          0,  1,  0,  1,  0, 32'h14,        32'h0,         7); // 20 halt
    add(0, 1, 32'hDEAD_BEEF,  0, 0, 32'h0,          0,  1,  0,  0,  1, 32'h14,        32'h0,         7); // 21 stray ack
    add(0, 0, 32'h0,          0, 0, 32'h0,          1,  1,  0,  0,  1, 32'h14,        32'h0,         7); // 22 resume
    add(1, 0, 32'h0,          0, 0, 32'h0,          0,  1,  1,  0,  0, 32'h18,        32'h0,         7); // 23 rst in REQ
    add(0, 1, 32'h1234_5678,  0, 0, 32'h0,          0,  1,  0,  0,  0, 32'h0,         c_NOP,         0); // 24 late ack
    add(0, 0, 32'h0,          0, 0, 32'h0,          0,  1,  1,  0,  0, 32'h0,         c_NOP,         0); // 25 REQ 0

    @(negedge clk);
    for (int i = 0; i < vq.size(); i++) begin
      rst = vq[i].rst; imem_ack = vq[i].ack; imem_rdata = vq[i].rdata;
      load = vq[i].load; pc_src = vq[i].src; pc_target = vq[i].tgt;
      resume = vq[i].res;
      #1;
      if (vq[i].chk) begin
        chk($sformatf("v%0d_req", i), {31'h0, imem_req}, {31'h0, vq[i].e_req});
        chk($sformatf("v%0d_valid", i), {31'h0, instr_valid}, {31'h0, vq[i].e_valid});
        chk($sformatf("v%0d_halted", i), {31'h0, halted}, {31'h0, vq[i].e_halted});
        chk($sformatf("v%0d_pc", i), pc, vq[i].e_pc);
        chk($sformatf("v%0d_instr", i), instr, vq[i].e_instr);
        chk($sformatf("v%0d_cnt", i), retired_cnt, c_CNT_EN ? vq[i].e_cnt : 32'h0);
        if (vq[i].e_req) chk($sformatf("v%0d_addr", i), imem_addr, vq[i].e_pc);
      end
      cyc();
    end

    // Halt at 8, long halt, resume, then retire count and PC wrap.
    idle_inputs();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    do_fetch("h0", 32'h0, 32'h33, 1'b1, 1'b0, 32'h0);
    do_fetch("h4", 32'h4, 32'h33, 1'b1, 1'b0, 32'h0);
    do_fetch("h8", 32'h8, 32'h0,  1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("halt%0d_halted", k), {31'h0, halted}, 32'h1);
      chk($sformatf("halt%0d_req", k), {31'h0, imem_req}, 32'h0);
      chk($sformatf("halt%0d_pc", k), pc, 32'h8);
      cyc();
    end
    chk("halt_cnt", retired_cnt, c_CNT_EN ? 32'd2 : 32'h0);
    resume = 1'b1;
    cyc();
    resume = 1'b0;
    chk("resume_req", {31'h0, imem_req}, 32'h1);
    chk("resume_addr", imem_addr, 32'hC);
    chk("resume_halted", {31'h0, halted}, 32'h0);
    do_fetch("rC",  32'hC,  32'h33, 1'b1, 1'b0, 32'h0);
    do_fetch("r10", 32'h10, 32'h33, 1'b1, 1'b0, 32'h0);
    do_fetch("r14", 32'h14, 32'h33, 1'b1, 1'b0, 32'h0);
    do_fetch("r18", 32'h18, 32'h0,  1'b0, 1'b0, 32'h0);
    chk("cnt5_halted", {31'h0, halted}, 32'h1);
    chk("cnt5_value", retired_cnt, c_CNT_EN ? 32'd5 : 32'h0);
    chk("cnt5_pc_plus4", pc_plus4, 32'h1C);
    resume = 1'b1;
    cyc();
    resume = 1'b0;
    do_fetch("w1C", 32'h1C, 32'h33, 1'b1, 1'b1, 32'hFFFF_FFFF);
    chk("wrap_pc", pc, 32'hFFFF_FFFC);
    chk("wrap_pc_plus4", pc_plus4, 32'h0);
    do_fetch("wFC", 32'hFFFF_FFFC, 32'h33, 1'b1, 1'b0, 32'h0);
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_cnt", retired_cnt, c_CNT_EN ? 32'd7 : 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
